// File: rtl/ram_nxm.sv
// Flop-based WIDTH x DEPTH synchronous RAM with a registered read port and a
// sequential fill engine that sweeps every word to all-zeros or all-ones.
module ram_nxm #(
    parameter  int WIDTH = 4,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             we,
    input  logic             re,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] din,
    input  logic             fill_req,
    input  logic             fill_val,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             busy
);

    typedef enum logic {
        S_IDLE,
        S_FILL
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_cnt;
    logic             r_pat;
    logic             r_busy;
    logic             r_valid;
    logic [WIDTH-1:0] r_dout;

    logic             w_last;
    logic             w_wr_en;
    logic [AW-1:0]    w_wr_addr;
    logic [WIDTH-1:0] w_wr_data;
    logic [WIDTH-1:0] w_rd_word;

    assign w_last = (r_cnt == AW'(DEPTH - 1));

    // Next state plus the single write port, shared by host writes and the sweep.
    always_comb begin
        w_state_next = r_state;
        w_wr_en      = 1'b0;
        w_wr_addr    = addr;
        w_wr_data    = din;
        case (r_state)
            S_IDLE: begin
                w_wr_en = we;
                if (fill_req) begin
                    w_state_next = S_FILL;
                end
            end
            S_FILL: begin
                w_wr_en   = 1'b1;
                w_wr_addr = r_cnt;
                w_wr_data = {WIDTH{r_pat}};
                if (w_last) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Addresses past DEPTH-1 match no word, so they read as zero.
    always_comb begin
        w_rd_word = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (addr == AW'(i)) begin
                w_rd_word = r_mem[i];
            end
        end
    end

    // Out-of-range write addresses match no word and are silently dropped.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_wr_addr == AW'(i)) begin
                    r_mem[i] <= w_wr_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_pat   <= 1'b0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_dout  <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    r_valid <= re;
                    if (re) begin
                        r_dout <= w_rd_word;
                    end
                    if (fill_req) begin
                        r_pat  <= fill_val;
                        r_cnt  <= '0;
                        r_busy <= 1'b1;
                    end
                end
                S_FILL: begin
                    r_valid <= 1'b0;
                    // Counter parks on the last word rather than wrapping.
                    if (w_last) begin
                        r_busy <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + AW'(1);
                    end
                end
                default: r_valid <= 1'b0;
            endcase
        end
    end

    assign dout  = r_dout;
    assign valid = r_valid;
    assign busy  = r_busy;

endmodule
